// File: rtl/gate_vector_checker.sv
// gate_vector_checker: checks AND2/OR2/NOT/NAND2/NOR2/XOR2/mux2 responses against golden values
// Ports: clk, rst (async, active-high); start begins/restarts a run from IDLE or DONE;
// in_valid/in_ready handshake carrying in_a, in_b, in_ctrl and in_obs {d,xor,nor,nand,not,or,and};
// busy/done/all_pass status; pass_cnt/fail_cnt counters; first_fail_idx/first_fail_mask capture
// (all-ones index and zero mask mean no failure yet).
module gate_vector_checker #(
    parameter int NUM_VECTORS = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_ctrl,
    input  logic [6:0]       in_obs,
    output logic             busy,
    output logic             done,
    output logic             all_pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [6:0]       first_fail_mask
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
    state_t state, state_n;
    logic [CNT_W-1:0] vec_idx;
    logic [6:0] golden, mismatch, dep;
    logic a_x, b_x, c_x, accept, clear;
    always_comb begin
        a_x = (in_a !== 1'b0) && (in_a !== 1'b1);
        b_x = (in_b !== 1'b0) && (in_b !== 1'b1);
        c_x = (in_ctrl !== 1'b0) && (in_ctrl !== 1'b1);
        golden = {in_ctrl ? in_b : in_a, in_a ^ in_b, ~(in_a | in_b), ~(in_a & in_b), ~in_a, in_a | in_b, in_a & in_b};
        // an unknown input poisons every output that depends on it, even if the observed value happens to match
        dep = {a_x | b_x | c_x, a_x | b_x, a_x | b_x, a_x | b_x, a_x, a_x | b_x, a_x | b_x};
        mismatch = dep;
        for (int i = 0; i < 7; i++) mismatch[i] = dep[i] | (in_obs[i] !== golden[i]);
        accept = in_valid && state == RUN;
        clear = start && state != RUN;
        state_n = clear ? RUN : (accept && vec_idx == LAST_IDX) ? DONE : state;
    end
    assign in_ready = state == RUN;
    assign busy = state == RUN;
    assign done = state == DONE;
    assign all_pass = done && fail_cnt == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            vec_idx <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
            first_fail_idx <= '1;
            first_fail_mask <= '0;
        end else begin
            state <= state_n;
            if (clear) begin
                vec_idx <= '0;
                pass_cnt <= '0;
                fail_cnt <= '0;
                first_fail_idx <= '1;
                first_fail_mask <= '0;
            end else if (accept) begin
                vec_idx <= vec_idx + 1'b1;
                if (|mismatch) begin
                    fail_cnt <= fail_cnt == CNT_MAX ? fail_cnt : fail_cnt + 1'b1;
                    if (fail_cnt == '0) begin
                        first_fail_idx <= vec_idx;
                        first_fail_mask <= mismatch;
                    end
                end else begin
                    pass_cnt <= pass_cnt == CNT_MAX ? pass_cnt : pass_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker: scoreboard bench for gate_vector_checker run results
module tb_gate_vector_checker;
    logic clk = 0, rst = 1, start = 0, in_valid = 0, in_a = 0, in_b = 0, in_ctrl = 0;
    logic [6:0] in_obs = '0, first_fail_mask;
    logic in_ready, busy, done, all_pass;
    logic [7:0] pass_cnt, fail_cnt, first_fail_idx;
    int errors = 0, checks = 0;
    typedef struct {
        logic [7:0] p, f, idx;
        logic [6:0] m;
        logic ap;
    } exp_t;
    exp_t q[$];
    // hand-computed correct {d,xor,nor,nand,not,or,and} for index i: a=i[0], b=i[1], ctrl=i[2]
    logic [6:0] good[8] = '{7'h1C, 7'h6A, 7'h2E, 7'h43, 7'h1C, 7'h2A, 7'h6E, 7'h43};
    logic [6:0] flip[8];
    logic done_q = 0;

    gate_vector_checker #(.NUM_VECTORS(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl), .in_obs(in_obs), .busy(busy),
        .done(done), .all_pass(all_pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_mask(first_fail_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done && !done_q) begin
            if (q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("pass_cnt", pass_cnt, e.p);
                chk("fail_cnt", fail_cnt, e.f);
                chk("first_fail_idx", first_fail_idx, e.idx);
                chk("first_fail_mask", first_fail_mask, e.m);
                chk("all_pass", all_pass, e.ap);
            end
        end
        done_q <= done;
    end

    task automatic send(input logic a, input logic b, input logic c, input logic [6:0] obs, input int gap);
        int t = 0;
        @(negedge clk);
        in_a = a; in_b = b; in_ctrl = c; in_obs = obs; in_valid = 1;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 0;
        repeat (gap) @(posedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1 start = 0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 50) begin @(negedge clk); t++; end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic run(input int gap, input logic x0);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            if (x0 && i == 0) send(v[0], v[1], v[2], 7'b0011x00, gap);
            else send(v[0], v[1], v[2], good[i] ^ flip[i], gap);
            if (i == 6) chk("not_done_before_8th", done, 0);
        end
        wait_done();
    endtask

    initial begin
        foreach (flip[i]) flip[i] = '0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_all_pass", all_pass, 0);
        chk("rst_pass_cnt", pass_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_ffi", first_fail_idx, 8'hFF);
        chk("rst_ffm", first_fail_mask, 0);
        @(negedge clk) rst = 0;
        // in_valid in IDLE is ignored, also on the start edge
        in_valid = 1; in_obs = 7'h7F;
        repeat (5) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 0);
        end
        chk("idle_pass_cnt", pass_cnt, 0);
        chk("idle_fail_cnt", fail_cnt, 0);
        start = 1;
        @(posedge clk);
        #1 start = 0; in_valid = 0;
        chk("run_busy", busy, 1);
        q.push_back('{8, 0, 8'hFF, 0, 1});
        run(0, 0);
        flip[3] = 7'h01;
        q.push_back('{7, 1, 3, 7'h01, 0});
        do_start(); run(0, 0);
        flip[3] = 0; flip[5] = 7'h40; flip[6] = 7'h20;
        q.push_back('{6, 2, 5, 7'h40, 0});
        do_start(); run(0, 0);
        foreach (flip[i]) flip[i] = '0;
        q.push_back('{8, 0, 8'hFF, 0, 1});
        do_start(); run(2, 0);
        q.push_back('{7, 1, 0, 7'h04, 0});
        do_start(); run(0, 1);
        q.push_back('{8, 0, 8'hFF, 0, 1});
        do_start(); run(0, 0);
        // asynchronous reset between edges after four accepts
        do_start();
        for (int i = 0; i < 4; i++) send(i[0], i[1], i[2], good[i], 0);
        chk("mid_pass_cnt", pass_cnt, 4);
        #2 rst = 1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 0);
        chk("arst_pass_cnt", pass_cnt, 0);
        chk("arst_ffi", first_fail_idx, 8'hFF);
        @(negedge clk) rst = 0;
        q.push_back('{8, 0, 8'hFF, 0, 1});
        do_start(); run(0, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
